// File: rtl/ysyx_24110015_key_reverse_lookup_if.sv
// Query/response handshake bundle for the key reverse-lookup table.
// master = requester side, slave = lookup engine side.
interface ysyx_24110015_key_reverse_lookup_if #(
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  parameter int IDX_W    = 2
);
  logic                q_valid;
  logic                q_ready;
  logic [DATA_LEN-1:0] q_data;
  logic                r_valid;
  logic                r_ready;
  logic                r_hit;
  logic [KEY_LEN-1:0]  r_key;
  logic [IDX_W-1:0]    r_idx;

  modport master (
    output q_valid, q_data, r_ready,
    input  q_ready, r_valid, r_hit, r_key, r_idx
  );

  modport slave (
    input  q_valid, q_data, r_ready,
    output q_ready, r_valid, r_hit, r_key, r_idx
  );
endinterface

// File: rtl/ysyx_24110015_key_reverse_lookup.sv
// Small key/data table with a sequential reverse lookup: given a data value,
// scan entries in ascending order and return the key of the first valid match.
//
// state | meaning
// IDLE  | q_ready=1, waiting for a query
// SCAN  | comparing one entry per cycle against the captured query
// RESP  | r_valid=1, holding the result until r_ready
module ysyx_24110015_key_reverse_lookup #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter int DEFAULT_KEY = 0,
  localparam int IDX_W      = (NR_KEY > 2) ? $clog2(NR_KEY) : 1,
  localparam int PAIR_LEN   = KEY_LEN + DATA_LEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [KEY_LEN-1:0]         wr_key,
  input  logic [DATA_LEN-1:0]        wr_data,
  ysyx_24110015_key_reverse_lookup_if.slave q_bus,
  output logic [NR_KEY*PAIR_LEN-1:0] lut_out,
  output logic [NR_KEY-1:0]          vld_out
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  logic [KEY_LEN-1:0]  key_mem  [NR_KEY];
  logic [DATA_LEN-1:0] data_mem [NR_KEY];
  logic [NR_KEY-1:0]   vld;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    scan_idx, scan_idx_nxt;
  logic [DATA_LEN-1:0] q_cap, q_cap_nxt;
  logic                hit_q, hit_nxt;
  logic [KEY_LEN-1:0]  key_q, key_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic                entry_match;

  // Out-of-range wr_idx matches no entry, so such writes fall through untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      for (int n = 0; n < NR_KEY; n++) begin
        key_mem[n]  <= '0;
        data_mem[n] <= '0;
      end
    end else if (clr) begin
      vld <= '0;
    end else if (wr_en) begin
      for (int n = 0; n < NR_KEY; n++) begin
        if (wr_idx == IDX_W'(n)) begin
          key_mem[n]  <= wr_key;
          data_mem[n] <= wr_data;
          vld[n]      <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    lut_out = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      lut_out[PAIR_LEN*n +: PAIR_LEN] = {key_mem[n], data_mem[n]};
    end
  end

  assign vld_out     = vld;
  assign entry_match = vld[scan_idx] && (data_mem[scan_idx] == q_cap);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      scan_idx <= '0;
      q_cap    <= '0;
      hit_q    <= 1'b0;
      key_q    <= '0;
      idx_q    <= '0;
    end else begin
      state    <= state_nxt;
      scan_idx <= scan_idx_nxt;
      q_cap    <= q_cap_nxt;
      hit_q    <= hit_nxt;
      key_q    <= key_nxt;
      idx_q    <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    scan_idx_nxt  = scan_idx;
    q_cap_nxt     = q_cap;
    hit_nxt       = hit_q;
    key_nxt       = key_q;
    idx_nxt       = idx_q;
    q_bus.q_ready = 1'b0;
    q_bus.r_valid = 1'b0;
    case (state)
      IDLE: begin
        q_bus.q_ready = 1'b1;
        if (q_bus.q_valid) begin
          q_cap_nxt    = q_bus.q_data;
          scan_idx_nxt = '0;
          state_nxt    = SCAN;
        end
      end
      SCAN: begin
        if (entry_match) begin
          hit_nxt   = 1'b1;
          key_nxt   = key_mem[scan_idx];
          idx_nxt   = scan_idx;
          state_nxt = RESP;
        end else if (scan_idx == IDX_W'(NR_KEY - 1)) begin
          hit_nxt   = 1'b0;
          key_nxt   = KEY_LEN'(DEFAULT_KEY);
          idx_nxt   = '0;
          state_nxt = RESP;
        end else begin
          scan_idx_nxt = scan_idx + 1'b1;
        end
      end
      RESP: begin
        q_bus.r_valid = 1'b1;
        if (q_bus.r_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign q_bus.r_hit = hit_q;
  assign q_bus.r_key = key_q;
  assign q_bus.r_idx = idx_q;

endmodule
